soc2_uart_stim: RTL

Parametrised UART serial-frame generator that drives a UART rx line with correctly timed frames. It replaces hand-forcing of receiver internals in soc2 top-level simulations, and doubles as a synthesizable loopback/stimulus source on the FPGA build. Bytes are queued in an internal FIFO and serialised LSB-first. Data width, parity, stop bits, inter-frame gap and per-frame framing-error injection are all configurable.

---
 rtl/soc2_uart_stim.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/soc2_uart_stim.sv
// soc2_uart_stim: UART frame generator. Bytes queued through a small FIFO are
// serialised LSB-first onto a registered, idle-high tx line. Data width,
// parity, stop bits and inter-frame gap are parameters. A per-byte error flag
// forces a framing error by driving the first stop bit low.
module soc2_uart_stim #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int IDLE_GAP     = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              enable,
  input  logic                              wr_valid,
  input  logic [DATA_BITS-1:0]              wr_data,
  input  logic                              wr_err,
  output logic                              wr_ready,
  output logic                              tx,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH+1);
  // One counter times both bit periods and the gap, so size it for the larger.
  localparam int BAUD_MAX = (IDLE_GAP > CLKS_PER_BIT) ? IDLE_GAP : CLKS_PER_BIT;
  localparam int BW       = $clog2(BAUD_MAX);
  localparam int NW       = $clog2(DATA_BITS);
  localparam int GAP_M1   = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t state, state_nxt;

  // ---------------- FIFO ----------------
  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [CW-1:0]        count;
  logic                 push, pop;
  logic [DATA_BITS:0]   rd_entry;

  assign wr_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign pop        = (state == S_IDLE) && enable && (count != '0);
  assign rd_entry   = mem[rptr];
  assign fifo_count = count;

  // Storage write; entries carry {err, data}.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wr_err, wr_data};
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- timing counters ----------------
  logic [BW-1:0]        baud;
  logic [NW-1:0]        bitn;
  logic                 bit_state, bit_end, data_last, stop_last, gap_last;

  assign bit_state = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
  assign bit_end   = bit_state && (baud == BW'(CLKS_PER_BIT-1));
  assign data_last = (bitn == NW'(DATA_BITS-1));
  assign stop_last = (bitn == NW'(STOP_BITS-1));
  assign gap_last  = (baud == BW'(GAP_M1));

  // Baud counter restarts at every bit boundary and state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud <= '0;
      bitn <= '0;
    end else begin
      if (state == S_IDLE || state_nxt != state || bit_end) baud <= '0;
      else                                               baud <= baud + 1'b1;
      if (state_nxt != state) bitn <= '0;
      else if (bit_end)       bitn <= bitn + 1'b1;
    end
  end

  // ---------------- frame datapath ----------------
  logic [DATA_BITS-1:0] shreg;
  logic                 err_q, par_q;

  // Load the popped entry, precompute parity, shift out data LSB-first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg <= '0;
      err_q <= 1'b0;
      par_q <= 1'b0;
    end else if (pop) begin
      shreg <= rd_entry[DATA_BITS-1:0];
      err_q <= rd_entry[DATA_BITS];
      par_q <= (^rd_entry[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
    end else if (state == S_DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pop) state_nxt = S_START;
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA:   if (bit_end && data_last)
                  state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP:   if (bit_end && stop_last)
                  state_nxt = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:    if (gap_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode; registered below so every output lags state by one cycle,
  // which puts the start bit on the 2nd edge after a push into an idle FIFO.
  logic tx_d, busy_d, done_d;
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state != S_IDLE);
    done_d = (state == S_STOP) && bit_end && stop_last;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = !(err_q && bitn == '0);
      default:  tx_d = 1'b1;
    endcase
  end

  // Output registers; reset forces the line idle without waiting for a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule
